serial_adder: RTL

Bit-serial WIDTH-bit adder built around the team's gate-level half-adder cells. Two half-adder cells form one full-adder cell, which is time-multiplexed over WIDTH cycles with a registered carry. Operands are accepted on a valid/ready input handshake and the sum is returned on a valid/ready output handshake. Sits downstream of operand sourcing logic and upstream of result consumers; it trades area for latency.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder_cell.sv | 28 ++
 rtl/half_adder_cell.sv | 12 +
 rtl/serial_adder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Full-adder cell composed of two half-adder cells and an OR of their carries.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  half_adder_cell u_ha0 (
    .a  (a),
    .b  (b),
    .s  (s0),
    .co (c0)
  );

  half_adder_cell u_ha1 (
    .a  (s0),
    .b  (cin),
    .s  (s),
    .co (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder_cell.sv
// Gate-level half-adder cell.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  assign s  = a ^ b;
  assign co = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement Overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             carry
);

  localparam int unsigned CntW = clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_q, sum_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic cy_q, cy_d, carry_q, carry_d;
  logic fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  full_adder_cell u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (cy_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    carry_d   = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          cy_d    = cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sum_d  = {fa_s, sum_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cy_d   = fa_co;
        if (cnt_q == CntLast) begin
          carry_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // cy_q here is the carry into the MSB
          ovf_d   = cy_q ^ fa_co;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule
